mmio_arbiter: RTL

MMIO_ARBITER -- requirements
Module: mmio_arbiter

---
 rtl/mmio_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 36 +++
 rtl/mmio_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mmio_arb_pkg.sv
// Shared types for the two-master FPro MMIO arbiter.
package mmio_arb_pkg;

    // Transaction sequencer states: sample/grant, bus strobe, completion pulse.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    // Identifies one of the two bus masters.
    typedef logic master_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic with its last_grant history register.
module rr_arb2
    import mmio_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       gnt_valid_o,
    output master_id_t gnt_id_o
);

    master_id_t last_grant_q;

    // Single requester always wins; on contention the master not granted last wins.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = 1'b0;
        unique case (req_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~last_grant_q;
            default: gnt_id_o = 1'b0;
        endcase
    end

    // Remember the accepted winner; reset to m1 so m0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (update_i && gnt_valid_o) begin
            last_grant_q <= gnt_id_o;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master arbiter in front of the FPro mmio_sys bus. Each granted request
// runs IDLE -> ISSUE (one strobe cycle) -> RESP (one ack cycle).
// Optional bus locking is built only when MMIO_ARB_LOCK_EN is defined.
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic              m0_lock,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m1_lock,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
);

    state_t            state_q;
    master_id_t        owner_q;
    logic              cs_q, wr_q, rd_q;
    logic              ack0_q, ack1_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd0_q, rd1_q;

    logic [1:0]        elig;
    logic              arb_update;
    logic              gnt_valid;
    master_id_t        gnt_id;

    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef MMIO_ARB_LOCK_EN
    logic       lock_q;
    master_id_t lock_owner_q;
    logic       lock_lat_q;

    // While locked only the lock owner is eligible, and the rotation history is frozen.
    assign elig[0]    = m0_req & (~lock_q | (lock_owner_q == 1'b0));
    assign elig[1]    = m1_req & (~lock_q | (lock_owner_q == 1'b1));
    assign arb_update = (state_q == IDLE) & ~lock_q;

    // Latch the winner's lock request alongside its command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_lat_q <= 1'b0;
        end else if (state_q == IDLE && gnt_valid) begin
            lock_lat_q <= gnt_id ? m1_lock : m0_lock;
        end
    end

    // Completion of a transaction sets or releases the lock for its owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
        end else if (state_q == RESP) begin
            lock_q       <= lock_lat_q;
            lock_owner_q <= owner_q;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = m0_lock ^ m1_lock;
    assign elig        = {m1_req, m0_req};
    assign arb_update  = (state_q == IDLE);
`endif

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req_i       (elig),
        .update_i    (arb_update),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // Winner's command, selected ahead of the latch.
    always_comb begin
        sel_wr    = gnt_id ? m1_wr      : m0_wr;
        sel_addr  = gnt_id ? m1_addr    : m0_addr;
        sel_wdata = gnt_id ? m1_wr_data : m0_wr_data;
    end

    // Sequencer and datapath; strobes and acks are registered and default low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            cs_q   <= 1'b0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        owner_q <= gnt_id;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        cs_q    <= 1'b1;
                        wr_q    <= sel_wr;
                        rd_q    <= ~sel_wr;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // mmio_rd_data is combinational from mmio_sys; capture it this cycle.
                    if (rd_q) begin
                        if (owner_q) rd1_q <= mmio_rd_data;
                        else         rd0_q <= mmio_rd_data;
                    end
                    if (owner_q) ack1_q <= 1'b1;
                    else         ack0_q <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mmio_cs      = cs_q;
    assign mmio_wr      = wr_q;
    assign mmio_rd      = rd_q;
    assign mmio_addr    = addr_q;
    assign mmio_wr_data = wdata_q;
    assign m0_ack       = ack0_q;
    assign m1_ack       = ack1_q;
    assign m0_rd_data   = rd0_q;
    assign m1_rd_data   = rd1_q;

endmodule
